// File: rtl/fib_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fib_seq_ctrl
//
// Clocked sequencer and consumer for an asynchronous two-phase dual-rail
// Fibonacci ring. The block enables the ring and synchronises its dual-rail
// output word. It waits for every bit to carry a token, decodes the token to
// binary and offers it on a valid/ready result stream. Once the consumer has
// taken the result it returns the two-phase acknowledge. Software asks for
// "N terms" through a command handshake. Between commands the acknowledge is
// withheld, so the ring stalls without losing a token.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset (shared with the ring)
//   cmd_valid  command request
//   cmd_ready  command accepted when cmd_valid && cmd_ready
//   cmd_count  number of terms to deliver (0 = no-op)
//   start      ring enable, held high from the first command until reset
//   ack_o      two-phase acknowledge to the ring
//   out_i      ring dual-rail word, [i][1] = true rail, [i][0] = false rail
//   res_valid  result available
//   res_ready  result consumed when res_valid && res_ready
//   res_data   binary term value
//   res_index  global term index since reset (wraps)
//   res_last   final term of the current command
//   busy       controller not idle
//   wrap_err   sticky: a term was smaller than the term before it
//   rail_err   sticky: both rails of one bit toggled within a token
// ---------------------------------------------------------------------------
module fib_seq_ctrl #(
    parameter int WIDTH       = 32,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [CNT_W-1:0]      cmd_count,
    output logic                  start,
    output logic                  ack_o,
    input  logic [WIDTH-1:0][1:0] out_i,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_data,
    output logic [CNT_W-1:0]      res_index,
    output logic                  res_last,
    output logic                  busy,
    output logic                  wrap_err,
    output logic                  rail_err
);

    // Stability counter only has to reach STABLE_CYC-1; the capture happens
    // on the cycle that would take it to STABLE_CYC.
    localparam int                STAB_W    = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD,
        S_ACKWAIT
    } state_e;

    // -----------------------------------------------------------------------
    // Rail synchroniser
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0][1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0][1:0] s;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the synchroniser array is reset on purpose. After reset it
            // agrees with prev_q (also zero), so no phantom token is seen.
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= out_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Completion detection and decode against the previous rail state
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0][1:0] prev_q;
    logic [WIDTH-1:0][1:0] s_last_q;
    logic [WIDTH-1:0]      tok;
    logic [WIDTH-1:0]      both;
    logic [WIDTH-1:0]      val;
    logic                  complete;
    logic                  rail_bad;
    logic                  stable_now;

    // NOTE: every combinational output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        tok  = '0;
        both = '0;
        val  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            tok[i]  = (s[i] != prev_q[i]);
            val[i]  = s[i][1] ^ prev_q[i][1];
            both[i] = (s[i][1] ^ prev_q[i][1]) & (s[i][0] ^ prev_q[i][0]);
        end
    end

    assign complete   = &tok;
    assign rail_bad   = |both;
    // A word counts toward stability only if it is complete and identical to
    // the word seen on the previous cycle. Skew and glitches reset the count.
    assign stable_now = complete && (s == s_last_q);

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs
    // -----------------------------------------------------------------------
    state_e              state_q;
    logic                cmd_ready_q;
    logic                start_q;
    logic                ack_q;
    logic                res_valid_q;
    logic [WIDTH-1:0]    res_data_q;
    logic [WIDTH-1:0]    last_term_q;
    logic [CNT_W-1:0]    index_q;
    logic [CNT_W-1:0]    remain_q;
    logic                res_last_q;
    logic                busy_q;
    logic                wrap_q;
    logic                rail_q;
    logic [STAB_W-1:0]   stab_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            start_q     <= 1'b0;
            ack_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            last_term_q <= '0;
            index_q     <= '0;
            remain_q    <= '0;
            res_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            wrap_q      <= 1'b0;
            rail_q      <= 1'b0;
            stab_q      <= '0;
            prev_q      <= '0;
            s_last_q    <= '0;
        end else begin
            s_last_q <= s;

            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        // start is set even by a zero-count command and never
                        // drops, so the ring never sees a spurious ack edge.
                        start_q <= 1'b1;
                        if (cmd_count != '0) begin
                            remain_q    <= cmd_count;
                            stab_q      <= '0;
                            cmd_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            state_q     <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (rail_bad) begin
                        rail_q <= 1'b1;
                    end
                    if (stable_now) begin
                        if (stab_q == STAB_LAST) begin
                            res_data_q  <= val;
                            res_valid_q <= 1'b1;
                            res_last_q  <= (remain_q == CNT_ONE);
                            state_q     <= S_HOLD;
                        end else begin
                            stab_q <= stab_q + STAB_W'(1);
                        end
                    end else begin
                        stab_q <= '0;
                    end
                end

                S_HOLD: begin
                    if ((index_q != '0) && (res_data_q < last_term_q)) begin
                        wrap_q <= 1'b1;
                    end
                    if (res_ready) begin
                        // The ring is stalled on this token, so s still holds
                        // it and becomes the reference for the next one.
                        prev_q      <= s;
                        ack_q       <= ~ack_q;
                        index_q     <= index_q + CNT_ONE;
                        remain_q    <= remain_q - CNT_ONE;
                        last_term_q <= res_data_q;
                        stab_q      <= '0;
                        res_valid_q <= 1'b0;
                        res_last_q  <= 1'b0;
                        if (remain_q > CNT_ONE) begin
                            state_q <= S_ACKWAIT;
                        end else begin
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= S_IDLE;
                        end
                    end
                end

                S_ACKWAIT: begin
                    // One cycle for prev_q to settle before the next token is
                    // compared against it.
                    state_q <= S_WAIT;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign start     = start_q;
    assign ack_o     = ack_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_index = index_q;
    assign res_last  = res_last_q;
    assign busy      = busy_q;
    assign wrap_err  = wrap_q;
    assign rail_err  = rail_q;

endmodule

// File: doc/fib_seq_ctrl.md
Name: fib_seq_ctrl

Overview:
- Clocked sequencer and consumer for the asynchronous two-phase (ENC "TP") dual-rail Fibonacci ring.
- Enables the ring, synchronises and completion-detects its dual-rail output word, and converts each token to binary.
- Presents each result on a valid/ready stream and returns the two-phase acknowledge.
- Software issues commands of "deliver N terms"; the controller withholds ack between commands so the ring stalls losslessly.

Parameters:
- WIDTH, 32, data bits of ring output (matches ring WIDTH)
- CNT_W, 16, width of term counters/index
- SYNC_STAGES, 2, flop stages on each incoming rail (min 2)
- STABLE_CYC, 2, consecutive cycles a complete word must be unchanged before capture (min 1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_count  in  CNT_W  number of terms to deliver (0 = no-op)
- start  out  1  ring enable (gates ring ack_i)
- ack_o  out  1  two-phase acknowledge to ring ack_i
- out_i  in  WIDTH x 2  ring dual-rail output, [i][1]=true rail, [i][0]=false rail
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid&&res_ready
- res_data  out  WIDTH  binary term value
- res_index  out  CNT_W  global term index since reset (wraps mod 2^CNT_W)
- res_last  out  1  final term of current command
- busy  out  1  state != IDLE
- wrap_err  out  1  sticky: term < previous term (arithmetic overflow)
- rail_err  out  1  sticky: both rails of a bit toggled in one token

Behaviour:
- Reset (rst=0, async): all outputs 0; state IDLE; prev rail register = 0; sync flops = 0; index = 0; remaining = 0; sticky errors cleared.
- start: 0 until first accepted command, then held 1 until reset. It never falls while ack_o=1, so the ring never sees a spurious ack edge.
- Synchroniser: each of the 2*WIDTH rails passes SYNC_STAGES flops; all detection uses synced rails s.
- Completion, per bit i: tok[i] = (s[i] != prev[i]).
  - Value bit = s[i][1]^prev[i][1].
  - rail_err sets if both rails differ from prev.
  - Word complete when all tok[i]=1.
- States:
  - IDLE: cmd_ready=1. On accept with count>0: remaining=count, go WAIT. On accept with count=0: consume, stay IDLE.
  - WAIT: word complete and equal to previous-cycle s -> increment stable counter; any change resets it. At STABLE_CYC -> capture value into res_data, go HOLD.
  - HOLD: res_valid=1, res_last=(remaining==1). On res_ready: prev<=s, ack_o toggles, index++, remaining--, stable counter cleared. Go to ACKWAIT if remaining>1, else IDLE.
  - ACKWAIT: one cycle minimum, so the ring cannot present the next token into stale prev. Then go WAIT.
- Ack timing: ack is issued only after the consumer takes the result. The last term of a command is acked on its handshake; the next token then sits in the ring until the next command.
- wrap_err: set in HOLD if index>0 and res_data < previous delivered term (compare held register).
- cmd_valid while busy: cmd_ready=0; the command waits.
- res_ready held high: throughput = one term per (SYNC_STAGES+STABLE_CYC+2) cycles plus ring latency.
- Mid-operation reset: immediate return to reset state. The ring shares rst and reinitialises; no partial result is reported.

Test Plan:
- Reset, cmd_count=7, res_ready=1 -> res_data 0,1,1,2,3,5,8; res_index 0..6; res_last only on 8; busy falls after; ack_o toggled 7 times.
- Two commands, count=3 then count=4 -> 0,1,1 then 2,3,5,8; no term lost or duplicated; ring stalled with start=1 between commands.
- res_ready low for 20 cycles in HOLD on term 3 -> res_data stays 2, ack_o unchanged, ring output unchanged; resumes correctly.
- WIDTH=8, count=16 -> terms match F(n) mod 256; wrap_err rises at index 14 (121<233) and stays set.
- Injected skew (bit 0 rail toggles 3 cycles after the others, or glitching before settling) -> no capture until STABLE_CYC stable cycles; value correct. Forced double-rail toggle -> rail_err=1.
- rst low during WAIT of term 4 -> all outputs 0 immediately; after release, count=2 -> 0,1.
